// File: rtl/input_conditioner.sv
// N-channel button/switch front end: synchroniser, debounce, press/release
// pulses, and long-press / auto-repeat strobes on selected channels.
module input_conditioner #(
    parameter int                  CHANNELS      = 10,
    parameter int                  SYNC_STAGES   = 2,
    parameter int                  STABLE_CYCLES = 400_000,
    parameter int                  HOLD_CYCLES   = 20_000_000,
    parameter int                  REPEAT_CYCLES = 4_000_000,
    parameter logic [CHANNELS-1:0] REPEAT_MASK   = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] in_raw,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] ondn,
    output logic [CHANNELS-1:0] onup,
    output logic [CHANNELS-1:0] long,
    output logic [CHANNELS-1:0] rpt
);

    localparam int DB_W   = $clog2(STABLE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int RPT_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(STABLE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } hold_state_t;

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        localparam bit MASKED = REPEAT_MASK[ch];

        logic              level_q, ondn_q, onup_q, long_q, rpt_q;
        logic [DB_W-1:0]   db_cnt;
        logic              flip, rise, fall;
        hold_state_t       state, state_nx;
        logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
        logic [RPT_W-1:0]  rpt_cnt, rpt_cnt_nx;
        logic              long_nx, rpt_nx;

        // A new level is accepted only after the counter has seen it persist
        // for the full stable window; any match in between restarts the count.
        assign flip = (s[ch] != level_q) && (db_cnt == DB_LAST);
        assign rise = flip & ~level_q;
        assign fall = flip & level_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                level_q <= 1'b0;
                ondn_q  <= 1'b0;
                onup_q  <= 1'b0;
                db_cnt  <= '0;
            end else begin
                ondn_q <= rise;
                onup_q <= fall;
                if (s[ch] == level_q) begin
                    db_cnt <= '0;
                end else if (flip) begin
                    db_cnt  <= '0;
                    level_q <= ~level_q;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state    <= IDLE;
                hold_cnt <= '0;
                rpt_cnt  <= '0;
                long_q   <= 1'b0;
                rpt_q    <= 1'b0;
            end else begin
                state    <= state_nx;
                hold_cnt <= hold_cnt_nx;
                rpt_cnt  <= rpt_cnt_nx;
                long_q   <= long_nx;
                rpt_q    <= rpt_nx;
            end
        end

        // Strobes are decided on the same edge that registers ondn/onup so
        // they line up with the press/release pulses.
        always_comb begin
            state_nx    = state;
            hold_cnt_nx = hold_cnt;
            rpt_cnt_nx  = rpt_cnt;
            long_nx     = 1'b0;
            rpt_nx      = 1'b0;
            if (!MASKED) begin
                state_nx = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state_nx    = HOLD;
                            hold_cnt_nx = '0;
                            rpt_nx      = 1'b1;
                        end
                    end
                    HOLD: begin
                        if (fall) begin
                            state_nx = IDLE;
                        end else if (hold_cnt == HOLD_LAST) begin
                            long_nx    = 1'b1;
                            rpt_nx     = 1'b1;
                            state_nx   = REPEAT;
                            rpt_cnt_nx = '0;
                        end else begin
                            hold_cnt_nx = hold_cnt + HOLD_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (fall) begin
                            state_nx = IDLE;
                        end else if (rpt_cnt == RPT_LAST) begin
                            rpt_nx     = 1'b1;
                            rpt_cnt_nx = '0;
                        end else begin
                            rpt_cnt_nx = rpt_cnt + RPT_W'(1);
                        end
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end

        assign out[ch]  = level_q;
        assign ondn[ch] = ondn_q;
        assign onup[ch] = onup_q;
        assign long[ch] = long_q;
        assign rpt[ch]  = rpt_q;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner: directed scenarios with literal
// expectations plus randomized pin activity checked against a timing model.
module tb_input_conditioner;

    localparam int           CH     = 4;
    localparam int           SYNC   = 2;
    localparam int           STABLE = 4;
    localparam int           HOLD   = 10;
    localparam int           REP    = 3;
    localparam logic [CH-1:0] MASK  = 4'b0010;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic [CH-1:0] in_raw = '0;
    logic [CH-1:0] out, ondn, onup, long, rpt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .CHANNELS      (CH),
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .REPEAT_MASK   (MASK)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_raw (in_raw),
        .out    (out),
        .ondn   (ondn),
        .onup   (onup),
        .long   (long),
        .rpt    (rpt)
    );

    // Model: pin samples travel through a SYNC-deep queue; a level is adopted
    // once STABLE+1 consecutive delayed samples disagree with it. Strobes are
    // pure arithmetic on the age of the current press.
    logic [CH-1:0] pipe_q[$];
    logic [CH-1:0] m_out, m_ondn, m_onup, m_long, m_rpt;
    int            run[CH];
    int            t_rise[CH];
    int            cyc;

    function automatic void model_clear();
        pipe_q.delete();
        for (int i = 0; i < SYNC; i++) pipe_q.push_back('0);
        m_out = '0; m_ondn = '0; m_onup = '0; m_long = '0; m_rpt = '0;
        for (int c = 0; c < CH; c++) begin
            run[c]    = 0;
            t_rise[c] = -1;
        end
    endfunction

    function automatic void model_step(input logic [CH-1:0] x);
        logic [CH-1:0] s;
        int            d;
        s = pipe_q.pop_front();
        pipe_q.push_back(x);
        cyc++;
        m_ondn = '0; m_onup = '0; m_long = '0; m_rpt = '0;
        for (int c = 0; c < CH; c++) begin
            if (s[c] != m_out[c]) begin
                run[c]++;
                if (run[c] == STABLE + 1) begin
                    run[c]   = 0;
                    m_out[c] = ~m_out[c];
                    if (m_out[c]) begin
                        m_ondn[c] = 1'b1;
                        t_rise[c] = cyc;
                    end else begin
                        m_onup[c] = 1'b1;
                        t_rise[c] = -1;
                    end
                end
            end else begin
                run[c] = 0;
            end
            if (MASK[c] && m_out[c] && t_rise[c] >= 0) begin
                d = cyc - t_rise[c];
                m_long[c] = (d == HOLD);
                m_rpt[c]  = (d == 0) || (d >= HOLD && ((d - HOLD) % REP) == 0);
            end
        end
    endfunction

    task automatic check_output(input string name, input logic [CH-1:0] act,
                                input logic [CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%b required=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs and reset only change on falling edges, so the value seen here
    // is exactly what the DUT sampled on this rising edge.
    always @(posedge clk) begin : compare
        logic [CH-1:0] x;
        logic          r;
        x = in_raw;
        r = reset;
        #1;
        if (!r) model_clear();
        else    model_step(x);
        check_output("out",  out,  m_out);
        check_output("ondn", ondn, m_ondn);
        check_output("onup", onup, m_onup);
        check_output("long", long, m_long);
        check_output("rpt",  rpt,  m_rpt);
    end

    task automatic apply_stimulus(input logic [CH-1:0] v);
        @(negedge clk);
        in_raw = v;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [CH-1:0] acc;
        logic [CH-1:0] v;
        int            rem[CH];

        cyc = 0;
        model_clear();

        wait_edges(2);
        check_output("rst_out",  out,  4'b0000);
        check_output("rst_ondn", ondn, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        wait_edges(3);

        // Short glitch on ch0 is filtered
        apply_stimulus(4'b0001);
        repeat (3) @(negedge clk);
        in_raw = 4'b0000;
        acc = '0;
        for (int k = 0; k < 12; k++) begin
            wait_edges(1);
            acc = acc | out | ondn | onup;
        end
        check_output("glitch_quiet", acc, 4'b0000);

        // Clean rise and fall on ch0
        apply_stimulus(4'b0001);
        wait_edges(6);
        check_output("rise_e5_out", out, 4'b0000);
        wait_edges(1);
        check_output("rise_e6_out",  out,  4'b0001);
        check_output("rise_e6_ondn", ondn, 4'b0001);
        wait_edges(1);
        check_output("rise_e7_ondn", ondn, 4'b0000);
        apply_stimulus(4'b0000);
        wait_edges(6);
        check_output("fall_e5_onup", onup, 4'b0000);
        wait_edges(1);
        check_output("fall_e6_onup", onup, 4'b0001);
        check_output("fall_e6_out",  out,  4'b0000);
        wait_edges(4);

        // Long press and auto-repeat on masked ch1
        apply_stimulus(4'b0010);
        wait_edges(7);
        check_output("hold_T_ondn", ondn, 4'b0010);
        check_output("hold_T_rpt",  rpt,  4'b0010);
        wait_edges(9);
        check_output("hold_T9_rpt",  rpt,  4'b0000);
        check_output("hold_T9_long", long, 4'b0000);
        wait_edges(1);
        check_output("hold_T10_long", long, 4'b0010);
        check_output("hold_T10_rpt",  rpt,  4'b0010);
        wait_edges(1);
        check_output("hold_T11_long", long, 4'b0000);
        wait_edges(2);
        check_output("hold_T13_rpt", rpt, 4'b0010);
        wait_edges(3);
        check_output("hold_T16_rpt", rpt, 4'b0010);
        apply_stimulus(4'b0000);
        wait_edges(7);
        check_output("hold_rel_onup", onup, 4'b0010);
        check_output("hold_rel_rpt",  rpt,  4'b0000);
        acc = '0;
        for (int k = 0; k < 15; k++) begin
            wait_edges(1);
            acc = acc | rpt | long;
        end
        check_output("hold_after_quiet", acc, 4'b0000);

        // Unmasked ch0 held long never strobes
        apply_stimulus(4'b0001);
        acc = '0;
        for (int k = 0; k < 50; k++) begin
            wait_edges(1);
            acc = acc | long | rpt;
        end
        check_output("unmasked_quiet", acc, 4'b0000);
        apply_stimulus(4'b0000);
        wait_edges(10);

        // Simultaneous rise on ch0 and ch2
        apply_stimulus(4'b0101);
        wait_edges(7);
        check_output("simul_ondn", ondn, 4'b0101);
        apply_stimulus(4'b0000);
        wait_edges(10);

        // Reset during repeat on ch1, input still held afterwards
        apply_stimulus(4'b0010);
        wait_edges(7);
        wait_edges(16);
        check_output("mid_rpt_before", rpt, 4'b0010);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("mid_rst_out",  out,  4'b0000);
        check_output("mid_rst_ondn", ondn, 4'b0000);
        check_output("mid_rst_onup", onup, 4'b0000);
        check_output("mid_rst_long", long, 4'b0000);
        check_output("mid_rst_rpt",  rpt,  4'b0000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_edges(6);
        check_output("rel_e5_ondn", ondn, 4'b0000);
        wait_edges(1);
        check_output("rel_e6_ondn", ondn, 4'b0010);
        check_output("rel_e6_rpt",  rpt,  4'b0010);
        apply_stimulus(4'b0000);
        wait_edges(10);

        // Randomized pin activity with occasional reset pulses
        v = in_raw;
        for (int c = 0; c < CH; c++) rem[c] = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 599) != 0);
            for (int c = 0; c < CH; c++) begin
                if (rem[c] == 0) begin
                    v[c]   = ~v[c];
                    rem[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                         : int'($urandom_range(6, 40));
                end else begin
                    rem[c]--;
                end
            end
            in_raw = v;
        end
        @(negedge clk);
        reset = 1'b1;
        wait_edges(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
